speriph_plug_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one cluster peripheral slave port (e.g. the event unit config port) between NB_PLUGS peripheral-interconnect plugs.
- Replaces a combinational plug mux. Provides fair arbitration, a grant lock while the slave stalls, and an in-order outstanding-transaction FIFO so that each response returns only to the plug that issued the request.
- Sits between the peripheral interconnect slave plugs and a single XBAR_PERIPH_BUS-style slave inside cluster peripherals.

---
 rtl/speriph_plug_rr_arbiter.sv | 171 +++++++++++++++++
 tb/tb_speriph_plug_rr_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/speriph_plug_rr_arbiter.sv
// speriph_plug_rr_arbiter
// Round-robin arbiter that shares one peripheral slave port between NB_PLUGS
// interconnect plugs. The request path is combinational. A granted-plug FIFO
// routes in-order responses back to the plug that issued each request. While
// the slave stalls, or the FIFO is full, the grant stays locked to the plug
// that was selected.
// Optional build macro: SPERIPH_ARB_PERF_EN adds the per-plug stall counters
// on perf_stall_cnt_o.
module speriph_plug_rr_arbiter #(
  parameter int NB_PLUGS        = 2,
  parameter int ID_WIDTH        = 5,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NB_PLUGS-1:0]                plug_req_i,
  input  logic [NB_PLUGS-1:0][31:0]          plug_add_i,
  input  logic [NB_PLUGS-1:0]                plug_wen_i,
  input  logic [NB_PLUGS-1:0][31:0]          plug_wdata_i,
  input  logic [NB_PLUGS-1:0][3:0]           plug_be_i,
  input  logic [NB_PLUGS-1:0][ID_WIDTH-1:0]  plug_id_i,
  output logic [NB_PLUGS-1:0]                plug_gnt_o,
  output logic [NB_PLUGS-1:0]                plug_r_valid_o,
  output logic [31:0]                        plug_r_rdata_o,
  output logic                               plug_r_opc_o,
  output logic [ID_WIDTH-1:0]                plug_r_id_o,
  output logic                               slv_req_o,
  output logic [31:0]                        slv_add_o,
  output logic                               slv_wen_o,
  output logic [31:0]                        slv_wdata_o,
  output logic [3:0]                         slv_be_o,
  output logic [ID_WIDTH-1:0]                slv_id_o,
  input  logic                               slv_gnt_i,
  input  logic                               slv_r_valid_i,
  input  logic [31:0]                        slv_r_rdata_i,
  input  logic                               slv_r_opc_i,
  input  logic [ID_WIDTH-1:0]                slv_r_id_i,
`ifdef SPERIPH_ARB_PERF_EN
  output logic [NB_PLUGS-1:0][15:0]          perf_stall_cnt_o,
`endif
  output logic                               err_unexp_rsp_o
);

  localparam int SEL_W = (NB_PLUGS > 1) ? $clog2(NB_PLUGS) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);
  localparam logic [SEL_W-1:0] PTR_RST  = SEL_W'(NB_PLUGS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_sel_q, lock_sel_d;
  logic [MAX_OUTSTANDING-1:0][SEL_W-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic [SEL_W-1:0] rr_sel, cand, sel, head;
  logic             found, req_sel, full, hs, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Round-robin pick starting after the last winner; a lock overrides it
  always_comb begin
    rr_sel = rr_ptr_q;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= NB_PLUGS; i++) begin
      cand = SEL_W'((int'(rr_ptr_q) + i) % NB_PLUGS);
      if (!found && plug_req_i[cand]) begin
        found  = 1'b1;
        rr_sel = cand;
      end
    end
    sel     = lock_q ? lock_sel_q : rr_sel;
    req_sel = plug_req_i[sel];
    full    = (count_q == CNT_FULL);
    hs      = req_sel && !full && slv_gnt_i;
  end

  // Forward the selected plug to the slave and return its grant
  always_comb begin
    slv_req_o   = req_sel && !full;
    slv_add_o   = plug_add_i[sel];
    slv_wen_o   = plug_wen_i[sel];
    slv_wdata_o = plug_wdata_i[sel];
    slv_be_o    = plug_be_i[sel];
    slv_id_o    = plug_id_i[sel];
    plug_gnt_o  = '0;
    if (hs) plug_gnt_o[sel] = 1'b1;
  end

  // Route a response to the FIFO head plug; an empty FIFO drops it
  always_comb begin
    head           = fifo_q[rd_ptr_q];
    pop            = slv_r_valid_i && (count_q != '0);
    plug_r_valid_o = '0;
    if (pop) plug_r_valid_o[head] = 1'b1;
    plug_r_rdata_o  = slv_r_rdata_i;
    plug_r_opc_o    = slv_r_opc_i;
    plug_r_id_o     = slv_r_id_i;
    err_unexp_rsp_o = err_q;
  end

  // Next state: RR pointer, lock, outstanding FIFO, sticky error
  always_comb begin
    rr_ptr_d   = hs ? sel : rr_ptr_q;
    // A pending, unserved request (slave stall or FIFO full) pins sel
    lock_d     = req_sel && !hs;
    lock_sel_d = sel;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (hs) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (hs && !pop)      count_d = count_q + CNT_W'(1);
    else if (!hs && pop) count_d = count_q - CNT_W'(1);
    err_d = err_q | (slv_r_valid_i && (count_q == '0));
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= PTR_RST;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

`ifdef SPERIPH_ARB_PERF_EN
  logic [NB_PLUGS-1:0][15:0] stall_cnt_q, stall_cnt_d;

  // Saturating per-plug count of cycles spent requesting without a grant
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    for (int i = 0; i < NB_PLUGS; i++)
      if (plug_req_i[i] && !plug_gnt_o[i] && (stall_cnt_q[i] != 16'hFFFF))
        stall_cnt_d[i] = stall_cnt_q[i] + 16'd1;
  end

  // Stall counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_speriph_plug_rr_arbiter.sv
// Directed bench for speriph_plug_rr_arbiter (NB_PLUGS=2, MAX_OUTSTANDING=2).
module tb_speriph_plug_rr_arbiter;
  localparam int NP = 2;
  localparam int IW = 5;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic [NP-1:0]          plug_req_i;
  logic [NP-1:0][31:0]    plug_add_i;
  logic [NP-1:0]          plug_wen_i;
  logic [NP-1:0][31:0]    plug_wdata_i;
  logic [NP-1:0][3:0]     plug_be_i;
  logic [NP-1:0][IW-1:0]  plug_id_i;
  logic [NP-1:0]          plug_gnt_o, plug_r_valid_o;
  logic [31:0]            plug_r_rdata_o;
  logic                   plug_r_opc_o;
  logic [IW-1:0]          plug_r_id_o;
  logic                   slv_req_o, slv_wen_o;
  logic [31:0]            slv_add_o, slv_wdata_o;
  logic [3:0]             slv_be_o;
  logic [IW-1:0]          slv_id_o;
  logic                   slv_gnt_i, slv_r_valid_i, slv_r_opc_i;
  logic [31:0]            slv_r_rdata_i;
  logic [IW-1:0]          slv_r_id_i;
  logic                   err_unexp_rsp_o;
`ifdef SPERIPH_ARB_PERF_EN
  logic [NP-1:0][15:0]    perf_stall_cnt_o;
`endif

  int total_cnt = 0;
  int pass_cnt  = 0;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;

  speriph_plug_rr_arbiter #(.NB_PLUGS(NP), .ID_WIDTH(IW), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .plug_req_i(plug_req_i), .plug_add_i(plug_add_i), .plug_wen_i(plug_wen_i),
    .plug_wdata_i(plug_wdata_i), .plug_be_i(plug_be_i), .plug_id_i(plug_id_i),
    .plug_gnt_o(plug_gnt_o), .plug_r_valid_o(plug_r_valid_o),
    .plug_r_rdata_o(plug_r_rdata_o), .plug_r_opc_o(plug_r_opc_o), .plug_r_id_o(plug_r_id_o),
    .slv_req_o(slv_req_o), .slv_add_o(slv_add_o), .slv_wen_o(slv_wen_o),
    .slv_wdata_o(slv_wdata_o), .slv_be_o(slv_be_o), .slv_id_o(slv_id_o),
    .slv_gnt_i(slv_gnt_i), .slv_r_valid_i(slv_r_valid_i), .slv_r_rdata_i(slv_r_rdata_i),
    .slv_r_opc_i(slv_r_opc_i), .slv_r_id_i(slv_r_id_i),
`ifdef SPERIPH_ARB_PERF_EN
    .perf_stall_cnt_o(perf_stall_cnt_o),
`endif
    .err_unexp_rsp_o(err_unexp_rsp_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change just after the falling edge; checks follow 1ns later
  task automatic step(input logic [NP-1:0] req, input logic gnt, input logic rv);
    @(negedge clk_i);
    plug_req_i    = req;
    slv_gnt_i     = gnt;
    slv_r_valid_i = rv;
    #1;
  endtask

  task automatic idle();
    plug_req_i    = '0;
    plug_add_i[0] = A0;  plug_add_i[1] = A1;
    plug_wen_i    = 2'b01;
    plug_wdata_i[0] = 32'h0000_00A0; plug_wdata_i[1] = 32'h0000_00A1;
    plug_be_i[0]  = 4'hF; plug_be_i[1] = 4'h3;
    plug_id_i[0]  = 5'd1; plug_id_i[1] = 5'd2;
    slv_gnt_i     = 1'b0;
    slv_r_valid_i = 1'b0;
    slv_r_rdata_i = '0;
    slv_r_opc_i   = 1'b0;
    slv_r_id_i    = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 1'b0;
    #12;
    total_cnt++; if (plug_gnt_o !== 2'b00) $display("FAIL reset_gnt got=%b exp=00", plug_gnt_o); else pass_cnt++;
    total_cnt++; if (plug_r_valid_o !== 2'b00) $display("FAIL reset_rvalid got=%b exp=00", plug_r_valid_o); else pass_cnt++;
    total_cnt++; if (slv_req_o !== 1'b0) $display("FAIL reset_slv_req got=%b exp=0", slv_req_o); else pass_cnt++;
    total_cnt++; if (err_unexp_rsp_o !== 1'b0) $display("FAIL reset_err got=%b exp=0", err_unexp_rsp_o); else pass_cnt++;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Contention alternates 0,1,0,1; responses each cycle return in grant order
  task automatic test_rr();
    logic [NP-1:0] eg, er;
    for (int k = 0; k < 4; k++) begin
      step(2'b11, 1'b1, k > 0);
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      er = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
      total_cnt++; if (plug_gnt_o !== eg) $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, plug_gnt_o, eg); else pass_cnt++;
      total_cnt++; if (slv_add_o !== ((k % 2 == 0) ? A0 : A1)) $display("FAIL rr_add k=%0d got=%h", k, slv_add_o); else pass_cnt++;
      total_cnt++; if (plug_r_valid_o !== er) $display("FAIL rr_rvalid k=%0d got=%b exp=%b", k, plug_r_valid_o, er); else pass_cnt++;
    end
    step(2'b00, 1'b0, 1'b1);
    total_cnt++; if (plug_r_valid_o !== 2'b10) $display("FAIL rr_drain got=%b exp=10", plug_r_valid_o); else pass_cnt++;
  endtask

  // Plug1 stalls; plug0 arrives with higher priority but the lock holds plug1
  task automatic test_lock();
    for (int c = 0; c < 3; c++) begin
      step((c == 0) ? 2'b10 : 2'b11, 1'b0, 1'b0);
      total_cnt++; if (slv_req_o !== 1'b1 || slv_add_o !== A1 || slv_id_o !== 5'd2)
        $display("FAIL lock_hold c=%0d req=%b add=%h id=%0d exp req=1 add=%h id=2", c, slv_req_o, slv_add_o, slv_id_o, A1); else pass_cnt++;
      total_cnt++; if (plug_gnt_o !== 2'b00) $display("FAIL lock_nogrant c=%0d got=%b exp=00", c, plug_gnt_o); else pass_cnt++;
    end
    step(2'b11, 1'b1, 1'b0);
    total_cnt++; if (plug_gnt_o !== 2'b10 || slv_add_o !== A1) $display("FAIL lock_grant gnt=%b add=%h exp gnt=10 add=%h", plug_gnt_o, slv_add_o, A1); else pass_cnt++;
    step(2'b01, 1'b1, 1'b0);
    total_cnt++; if (plug_gnt_o !== 2'b01 || slv_be_o !== 4'hF) $display("FAIL lock_next gnt=%b be=%h exp gnt=01 be=f", plug_gnt_o, slv_be_o); else pass_cnt++;
    step(2'b00, 1'b0, 1'b1);
    total_cnt++; if (plug_r_valid_o !== 2'b10) $display("FAIL lock_rsp0 got=%b exp=10", plug_r_valid_o); else pass_cnt++;
    step(2'b00, 1'b0, 1'b1);
    total_cnt++; if (plug_r_valid_o !== 2'b01) $display("FAIL lock_rsp1 got=%b exp=01", plug_r_valid_o); else pass_cnt++;
  endtask

  // Two grants fill the FIFO; the third waits until a response, no bypass
  task automatic test_full();
    step(2'b11, 1'b1, 1'b0);
    total_cnt++; if (plug_gnt_o !== 2'b10) $display("FAIL full_g1 got=%b exp=10", plug_gnt_o); else pass_cnt++;
    step(2'b11, 1'b1, 1'b0);
    total_cnt++; if (plug_gnt_o !== 2'b01) $display("FAIL full_g2 got=%b exp=01", plug_gnt_o); else pass_cnt++;
    step(2'b11, 1'b1, 1'b0);
    total_cnt++; if (slv_req_o !== 1'b0 || plug_gnt_o !== 2'b00) $display("FAIL full_block req=%b gnt=%b exp req=0 gnt=00", slv_req_o, plug_gnt_o); else pass_cnt++;
    slv_r_rdata_i = 32'hDEADBEEF;
    step(2'b11, 1'b1, 1'b1);
    total_cnt++; if (plug_r_valid_o !== 2'b10 || plug_r_rdata_o !== 32'hDEADBEEF)
      $display("FAIL full_rsp rvalid=%b rdata=%h exp rvalid=10 rdata=deadbeef", plug_r_valid_o, plug_r_rdata_o); else pass_cnt++;
    total_cnt++; if (slv_req_o !== 1'b0) $display("FAIL full_nobypass got=%b exp=0", slv_req_o); else pass_cnt++;
    slv_r_rdata_i = '0;
    step(2'b11, 1'b1, 1'b0);
    total_cnt++; if (plug_gnt_o !== 2'b10) $display("FAIL full_g3 got=%b exp=10", plug_gnt_o); else pass_cnt++;
    step(2'b00, 1'b0, 1'b1);
    total_cnt++; if (plug_r_valid_o !== 2'b01) $display("FAIL full_rsp2 got=%b exp=01", plug_r_valid_o); else pass_cnt++;
    step(2'b00, 1'b0, 1'b1);
    total_cnt++; if (plug_r_valid_o !== 2'b10) $display("FAIL full_rsp3 got=%b exp=10", plug_r_valid_o); else pass_cnt++;
  endtask

  // Grants to plug1 then plug0; responses carry ids 3 and 7
  task automatic test_order();
    step(2'b10, 1'b1, 1'b0);
    total_cnt++; if (plug_gnt_o !== 2'b10) $display("FAIL ord_g1 got=%b exp=10", plug_gnt_o); else pass_cnt++;
    step(2'b01, 1'b1, 1'b0);
    total_cnt++; if (plug_gnt_o !== 2'b01) $display("FAIL ord_g0 got=%b exp=01", plug_gnt_o); else pass_cnt++;
    slv_r_id_i = 5'd3;
    step(2'b00, 1'b0, 1'b1);
    total_cnt++; if (plug_r_valid_o !== 2'b10 || plug_r_id_o !== 5'd3)
      $display("FAIL ord_rsp1 rvalid=%b id=%0d exp rvalid=10 id=3", plug_r_valid_o, plug_r_id_o); else pass_cnt++;
    slv_r_id_i = 5'd7; slv_r_opc_i = 1'b1;
    step(2'b00, 1'b0, 1'b1);
    total_cnt++; if (plug_r_valid_o !== 2'b01 || plug_r_id_o !== 5'd7 || plug_r_opc_o !== 1'b1)
      $display("FAIL ord_rsp2 rvalid=%b id=%0d opc=%b exp rvalid=01 id=7 opc=1", plug_r_valid_o, plug_r_id_o, plug_r_opc_o); else pass_cnt++;
    slv_r_id_i = '0; slv_r_opc_i = 1'b0;
  endtask

  // Reset mid-transaction discards the outstanding entry; its late response is unexpected
  task automatic test_unexp();
    step(2'b01, 1'b1, 1'b0);
    total_cnt++; if (plug_gnt_o !== 2'b01) $display("FAIL unexp_grant got=%b exp=01", plug_gnt_o); else pass_cnt++;
    do_reset();
    step(2'b00, 1'b0, 1'b1);
    total_cnt++; if (plug_r_valid_o !== 2'b00) $display("FAIL unexp_drop got=%b exp=00", plug_r_valid_o); else pass_cnt++;
    total_cnt++; if (err_unexp_rsp_o !== 1'b0) $display("FAIL unexp_err_pre got=%b exp=0", err_unexp_rsp_o); else pass_cnt++;
    step(2'b00, 1'b0, 1'b0);
    total_cnt++; if (err_unexp_rsp_o !== 1'b1) $display("FAIL unexp_err_set got=%b exp=1", err_unexp_rsp_o); else pass_cnt++;
    repeat (3) step(2'b00, 1'b0, 1'b0);
    total_cnt++; if (err_unexp_rsp_o !== 1'b1) $display("FAIL unexp_err_sticky got=%b exp=1", err_unexp_rsp_o); else pass_cnt++;
    rst_ni = 1'b0;
    #1;
    total_cnt++; if (err_unexp_rsp_o !== 1'b0) $display("FAIL unexp_err_clr got=%b exp=0", err_unexp_rsp_o); else pass_cnt++;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

`ifdef SPERIPH_ARB_PERF_EN
  // Plug1 waits 5 cycles on a stalled slave while plug0 stays idle
  task automatic test_perf();
    repeat (5) step(2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b0);
    total_cnt++; if (plug_gnt_o !== 2'b10) $display("FAIL perf_grant got=%b exp=10", plug_gnt_o); else pass_cnt++;
    step(2'b00, 1'b0, 1'b1);
    total_cnt++; if (perf_stall_cnt_o[1] !== 16'd5) $display("FAIL perf_cnt1 got=%0d exp=5", perf_stall_cnt_o[1]); else pass_cnt++;
    total_cnt++; if (perf_stall_cnt_o[0] !== 16'd0) $display("FAIL perf_cnt0 got=%0d exp=0", perf_stall_cnt_o[0]); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_rr();
    test_lock();
    test_full();
    test_order();
    test_unexp();
`ifdef SPERIPH_ARB_PERF_EN
    test_perf();
`endif
    step(2'b00, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
